multicycle_controller: RTL

- Finite-state sequencer for the multicycle RV32I datapath.
- Each instruction is split into fetch, decode, execute, memory and writeback steps over a shared ALU, a single unified memory port and the register file.
- Drives the ALU operand and function selects, the enables for PC, instruction register, register file and memory, and the result/address muxes.
- Inserts wait states while memory is not ready.

---
 rtl/multicycle_controller.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback.
// Define UTYPE_EN to support LUI/AUIPC through the EXECU state.
module multicycle_controller (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] Op_i,
    input  logic [2:0] Funct3_i,
    input  logic       Funct7_5_i,
    input  logic       Zero_i,
    input  logic       MemReady_i,
    output logic       PCWrite_o,
    output logic       AdrSrc_o,
    output logic       IRWrite_o,
    output logic       MemWrite_o,
    output logic       RegWrite_o,
    output logic [1:0] ResultSrc_o,
    output logic [1:0] ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [3:0] ALUCtrl_o,
    output logic [2:0] ImmSrc_o,
    output logic       IllegalInstr_o,
    output logic [3:0] State_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12,
        S_EXECU    = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'd3;
    localparam logic [6:0] OP_STORE = 7'd35;
    localparam logic [6:0] OP_R     = 7'd51;
    localparam logic [6:0] OP_I     = 7'd19;
    localparam logic [6:0] OP_BR    = 7'd99;
    localparam logic [6:0] OP_JAL   = 7'd111;
    localparam logic [6:0] OP_JALR  = 7'd103;
    localparam logic [6:0] OP_AUIPC = 7'd23;
    localparam logic [6:0] OP_LUI   = 7'd55;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    state_t     r_state;
    state_t     w_cur;
    state_t     w_next;
    logic       w_pcw;
    logic       w_irw;
    logic       w_memw;
    logic       w_regw;
    logic       w_ill;
    logic       w_br_ok;

    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
        logic [3:0] r;
        r = ALU_ADD;
        unique case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    // Reset overrides the registered state so outputs show FETCH immediately
    assign w_cur   = rst_i ? S_FETCH : r_state;
    assign w_br_ok = (Funct3_i == 3'b000) || (Funct3_i == 3'b001);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = w_cur;
        w_pcw       = 1'b0;
        w_irw       = 1'b0;
        w_memw      = 1'b0;
        w_regw      = 1'b0;
        w_ill       = 1'b0;
        AdrSrc_o    = 1'b0;
        ResultSrc_o = 2'b00;
        ALUSrcA_o   = 2'b00;
        ALUSrcB_o   = 2'b00;
        ALUCtrl_o   = ALU_ADD;
        unique case (w_cur)
            S_FETCH: begin
                ALUSrcB_o   = 2'b10;
                ResultSrc_o = 2'b10;
                w_irw       = MemReady_i;
                w_pcw       = MemReady_i;
                if (MemReady_i) w_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA_o = 2'b01;
                ALUSrcB_o = 2'b01;
                unique case (Op_i)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXECR;
                    OP_I:              w_next = S_EXECI;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR1;
                    OP_BR: begin
                        w_next = w_br_ok ? S_BRANCH : S_FETCH;
                        w_ill  = ~w_br_ok;
                    end
`ifdef UTYPE_EN
                    OP_AUIPC, OP_LUI:  w_next = S_EXECU;
`endif
                    default: begin
                        w_next = S_FETCH;
                        w_ill  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA_o = 2'b10;
                ALUSrcB_o = 2'b01;
                w_next    = (Op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc_o = 1'b1;
                if (MemReady_i) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc_o = 2'b01;
                w_regw      = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc_o = 1'b1;
                w_memw   = 1'b1;
                if (MemReady_i) w_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA_o = 2'b10;
                ALUCtrl_o = alu_dec(Funct3_i, Funct7_5_i);
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA_o = 2'b10;
                ALUSrcB_o = 2'b01;
                // Only SRAI uses bit 30; for ADDI it is immediate data
                ALUCtrl_o = alu_dec(Funct3_i, (Funct3_i == 3'b101) & Funct7_5_i);
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regw = 1'b1;
                w_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA_o = 2'b10;
                ALUCtrl_o = ALU_SUB;
                w_pcw     = Funct3_i[0] ? ~Zero_i : Zero_i;
                w_next    = S_FETCH;
            end
            S_JAL: begin
                w_pcw     = 1'b1;
                ALUSrcA_o = 2'b01;
                ALUSrcB_o = 2'b10;
                w_next    = S_ALUWB;
            end
            S_JALR1: begin
                ALUSrcA_o = 2'b10;
                ALUSrcB_o = 2'b01;
                w_next    = S_JALR2;
            end
            S_JALR2: begin
                w_pcw     = 1'b1;
                ALUSrcA_o = 2'b01;
                ALUSrcB_o = 2'b10;
                w_next    = S_ALUWB;
            end
`ifdef UTYPE_EN
            S_EXECU: begin
                ALUSrcA_o = (Op_i == OP_LUI) ? 2'b11 : 2'b01;
                ALUSrcB_o = 2'b01;
                w_next    = S_ALUWB;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        ImmSrc_o = 3'b000;
        unique case (Op_i)
            OP_LOAD, OP_I, OP_JALR: ImmSrc_o = 3'b000;
            OP_STORE:               ImmSrc_o = 3'b001;
            OP_BR:                  ImmSrc_o = 3'b010;
            OP_AUIPC, OP_LUI:       ImmSrc_o = 3'b011;
            OP_JAL:                 ImmSrc_o = 3'b100;
            default:                ImmSrc_o = 3'b000;
        endcase
    end

    assign PCWrite_o      = w_pcw  & ~rst_i;
    assign IRWrite_o      = w_irw  & ~rst_i;
    assign MemWrite_o     = w_memw & ~rst_i;
    assign RegWrite_o     = w_regw & ~rst_i;
    assign IllegalInstr_o = w_ill  & ~rst_i;
    assign State_o        = w_cur;

endmodule
